// File: rtl/line_move_scan_pkg.sv
// line_move_scan_pkg: shared line/position types, scan state enum and bit-reversal helper
package line_move_scan_pkg;
  typedef logic [7:0] line_t;
  typedef logic [2:0] pos_t;
  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
  function automatic line_t rev8(input line_t x);
    line_t r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction
endpackage

// File: rtl/line_flip_dir.sv
// line_flip_dir: upward flip mask for a move at pos (opponent run from pos+1 capped by a player stone)
module line_flip_dir
  import line_move_scan_pkg::*;
(
  input  line_t player,
  input  line_t opponent,
  input  pos_t  pos,
  output line_t flip
);
  line_t run_mask;
  logic  run, hit;
  always_comb begin
    run_mask = '0;
    run = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > int'(pos) && run) begin
        if (opponent[i]) run_mask[i] = 1'b1;
        else begin
          run = 1'b0;
          hit = player[i];
        end
      end
    end
    flip = hit ? run_mask : '0;
  end
endmodule

// File: rtl/line_move_scan.sv
// line_move_scan: steps cells 0..7 of an Othello line and streams each legal move with its flip mask and resulting line
module line_move_scan
  import line_move_scan_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  line_t      player,
  input  line_t      opponent,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output pos_t       out_pos,
  output line_t      out_flip,
  output line_t      out_player,
  output line_t      out_opponent,
  output logic       done,
  output logic [3:0] move_count
);
  state_t state, state_nx;
  line_t  ply, opp, flip_up, flip_dn_r, flip;
  pos_t   pos;
  logic   legal, last;
  line_flip_dir u_up (.player(ply), .opponent(opp), .pos(pos), .flip(flip_up));
  // the downward search reuses the upward block on the mirrored line; ~pos is 7-pos
  line_flip_dir u_dn (.player(rev8(ply)), .opponent(rev8(opp)), .pos(~pos), .flip(flip_dn_r));
  assign flip  = flip_up | rev8(flip_dn_r);
  assign legal = !ply[pos] && !opp[pos] && |flip;
  assign last  = pos == 3'd7;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? SCAN : IDLE) :
               state == SCAN ? (legal ? EMIT : last ? DONE : SCAN) :
               state == EMIT ? (out_ready ? (last ? DONE : SCAN) : EMIT) :
                               IDLE;
  always_comb begin
    busy      = state != IDLE;
    out_valid = state == EMIT;
    done      = state == DONE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ply          <= '0;
      opp          <= '0;
      pos          <= '0;
      out_pos      <= '0;
      out_flip     <= '0;
      out_player   <= '0;
      out_opponent <= '0;
      move_count   <= '0;
    end else begin
      if (state == IDLE && start) begin
        ply        <= player;
        opp        <= opponent & ~player;
        pos        <= '0;
        move_count <= '0;
      end
      if (state == SCAN) begin
        if (legal) begin
          out_pos      <= pos;
          out_flip     <= flip;
          out_player   <= ply | flip | line_t'(1 << pos);
          out_opponent <= opp & ~flip;
          move_count   <= move_count + 4'd1;
        end else if (!last) pos <= pos + 3'd1;
      end
      if (state == EMIT && out_ready && !last) pos <= pos + 3'd1;
    end
  end
endmodule

// File: tb/tb_line_move_scan.sv
// tb_line_move_scan: directed self-checking bench for the line move enumerator
module tb_line_move_scan;
  logic       clock = 0, reset = 1, start = 0, out_ready = 1;
  logic [7:0] player = 0, opponent = 0;
  logic       busy, out_valid, done;
  logic [2:0] out_pos;
  logic [7:0] out_flip, out_player, out_opponent;
  logic [3:0] move_count;
  int errors = 0, checks = 0;
  logic [2:0] r_pos [8];
  logic [7:0] r_flip [8], r_ply [8], r_opp [8];
  int r_n, d_cyc;
  logic d_seen;

  line_move_scan dut (
    .clock(clock), .reset(reset), .start(start), .player(player), .opponent(opponent),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos),
    .out_flip(out_flip), .out_player(out_player), .out_opponent(out_opponent),
    .done(done), .move_count(move_count)
  );

  always #5 clock = ~clock;

  task automatic run_scan(input logic [7:0] pl, input logic [7:0] op);
    int c;
    r_n = 0; d_seen = 0; d_cyc = 0; out_ready = 1;
    @(negedge clock); player = pl; opponent = op; start = 1;
    @(negedge clock); start = 0;
    c = 1;
    while (c <= 40 && !d_seen) begin
      if (c > 1) @(negedge clock);
      if (out_valid && r_n < 8) begin
        r_pos[r_n] = out_pos; r_flip[r_n] = out_flip; r_ply[r_n] = out_player; r_opp[r_n] = out_opponent;
        r_n++;
      end
      if (done) begin d_seen = 1; d_cyc = c; end
      c++;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if ({busy, out_valid, done, move_count} !== 7'd0) begin errors++; $display("FAIL reset_ctrl got %b want 0", {busy, out_valid, done, move_count}); end
    checks++; if ({out_pos, out_flip, out_player, out_opponent} !== 27'd0) begin errors++; $display("FAIL reset_data got %h want 0", {out_pos, out_flip, out_player, out_opponent}); end
    @(negedge clock); reset = 0;
  endtask

  task automatic test_single;
    run_scan(8'h01, 8'h02);
    checks++; if (r_n !== 1) begin errors++; $display("FAIL single_count got %0d want 1", r_n); end
    checks++; if ({r_pos[0], r_flip[0], r_ply[0], r_opp[0]} !== {3'd2, 8'h02, 8'h07, 8'h00}) begin errors++; $display("FAIL single_rec got %h %h %h %h want 2 02 07 00", r_pos[0], r_flip[0], r_ply[0], r_opp[0]); end
    checks++; if (!d_seen || move_count !== 4'd1) begin errors++; $display("FAIL single_done got seen=%b mc=%0d want 1 1", d_seen, move_count); end
  endtask

  task automatic test_full;
    run_scan(8'h81, 8'h7E);
    checks++; if (r_n !== 0) begin errors++; $display("FAIL full_count got %0d want 0", r_n); end
    checks++; if (d_cyc !== 9) begin errors++; $display("FAIL full_done_cycle got %0d want 9", d_cyc); end
    checks++; if (move_count !== 4'd0) begin errors++; $display("FAIL full_mc got %0d want 0", move_count); end
    @(negedge clock);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL full_idle got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_two;
    run_scan(8'h10, 8'h28);
    checks++; if (r_n !== 2) begin errors++; $display("FAIL two_count got %0d want 2", r_n); end
    checks++; if ({r_pos[0], r_flip[0], r_ply[0], r_opp[0]} !== {3'd2, 8'h08, 8'h1C, 8'h20}) begin errors++; $display("FAIL two_rec1 got %h %h %h %h want 2 08 1c 20", r_pos[0], r_flip[0], r_ply[0], r_opp[0]); end
    checks++; if ({r_pos[1], r_flip[1], r_ply[1], r_opp[1]} !== {3'd6, 8'h20, 8'h70, 8'h08}) begin errors++; $display("FAIL two_rec2 got %h %h %h %h want 6 20 70 08", r_pos[1], r_flip[1], r_ply[1], r_opp[1]); end
    checks++; if (d_cyc !== 11 || move_count !== 4'd2) begin errors++; $display("FAIL two_done got cyc=%0d mc=%0d want 11 2", d_cyc, move_count); end
  endtask

  task automatic test_stall;
    int c, n, v1;
    n = 0; v1 = 0; d_seen = 0; d_cyc = 0;
    @(negedge clock); player = 8'h10; opponent = 8'h28; start = 1; out_ready = 0;
    @(negedge clock); start = 0;
    c = 1;
    while (c <= 40 && !d_seen) begin
      if (c > 1) @(negedge clock);
      if (out_valid) begin
        if (n == 0) begin
          v1++;
          checks++; if ({out_pos, out_flip, out_player, out_opponent} !== {3'd2, 8'h08, 8'h1C, 8'h20}) begin errors++; $display("FAIL stall_rec1 cycle %0d got %h %h %h %h want 2 08 1c 20", v1, out_pos, out_flip, out_player, out_opponent); end
          if (v1 == 4) begin out_ready = 1; n = 1; end
        end else if (n == 1) begin
          checks++; if ({out_pos, out_flip, out_player, out_opponent} !== {3'd6, 8'h20, 8'h70, 8'h08}) begin errors++; $display("FAIL stall_rec2 got %h %h %h %h want 6 20 70 08", out_pos, out_flip, out_player, out_opponent); end
          n = 2;
        end
      end
      if (done) begin d_seen = 1; d_cyc = c; end
      c++;
    end
    checks++; if (v1 !== 4 || n !== 2) begin errors++; $display("FAIL stall_count got v1=%0d n=%0d want 4 2", v1, n); end
    checks++; if (d_cyc !== 14 || move_count !== 4'd2) begin errors++; $display("FAIL stall_done got cyc=%0d mc=%0d want 14 2", d_cyc, move_count); end
    out_ready = 1;
  endtask

  task automatic test_start_busy;
    int c;
    r_n = 0; d_seen = 0; d_cyc = 0; out_ready = 1;
    @(negedge clock); player = 8'h10; opponent = 8'h28; start = 1;
    @(negedge clock); start = 0;
    c = 1;
    while (c <= 40 && !d_seen) begin
      if (c > 1) @(negedge clock);
      if (c == 3) begin start = 1; player = 8'h01; opponent = 8'h02; end
      if (c == 4) begin start = 0; player = 8'h10; opponent = 8'h28; end
      if (out_valid && r_n < 8) begin
        r_pos[r_n] = out_pos; r_flip[r_n] = out_flip; r_ply[r_n] = out_player; r_opp[r_n] = out_opponent;
        r_n++;
      end
      if (done) begin d_seen = 1; d_cyc = c; end
      c++;
    end
    checks++; if (r_n !== 2) begin errors++; $display("FAIL busy_start_count got %0d want 2", r_n); end
    checks++; if ({r_pos[0], r_flip[0], r_pos[1], r_flip[1]} !== {3'd2, 8'h08, 3'd6, 8'h20}) begin errors++; $display("FAIL busy_start_recs got %h %h %h %h want 2 08 6 20", r_pos[0], r_flip[0], r_pos[1], r_flip[1]); end
    checks++; if (r_ply[1] !== 8'h70 || r_opp[1] !== 8'h08) begin errors++; $display("FAIL busy_start_lines got %h %h want 70 08", r_ply[1], r_opp[1]); end
    checks++; if (d_cyc !== 11) begin errors++; $display("FAIL busy_start_done got %0d want 11", d_cyc); end
  endtask

  task automatic test_reset_emit;
    int c, dones;
    logic got;
    got = 0; dones = 0;
    @(negedge clock); player = 8'h01; opponent = 8'h02; start = 1; out_ready = 0;
    @(negedge clock); start = 0;
    c = 1;
    while (c <= 20 && !got) begin
      if (c > 1) @(negedge clock);
      if (out_valid) got = 1;
      c++;
    end
    checks++; if (!got || move_count !== 4'd1) begin errors++; $display("FAIL remit_reach got valid=%b mc=%0d want 1 1", got, move_count); end
    reset = 1; #1;
    checks++; if ({out_valid, busy, done, move_count} !== 7'd0) begin errors++; $display("FAIL remit_ctrl got %b want 0", {out_valid, busy, done, move_count}); end
    checks++; if ({out_pos, out_flip, out_player, out_opponent} !== 27'd0) begin errors++; $display("FAIL remit_data got %h want 0", {out_pos, out_flip, out_player, out_opponent}); end
    @(negedge clock); reset = 0; out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done || busy) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL remit_quiet got %0d want 0", dones); end
    run_scan(8'h01, 8'h02);
    checks++; if (r_n !== 1 || r_pos[0] !== 3'd2 || r_flip[0] !== 8'h02 || move_count !== 4'd1) begin errors++; $display("FAIL remit_rescan got n=%0d pos=%0d flip=%h mc=%0d want 1 2 02 1", r_n, r_pos[0], r_flip[0], move_count); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_full;
    test_two;
    test_stall;
    test_start_busy;
    test_reset_emit;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
